aes_key_expand_seq: RTL and testbench
=====================================

# aes_key_expand_seq

Iterative AES-128 key-schedule generator that sits directly upstream of the `AES` encryption core and drives its `fullkeys[1407:0]` input. It replaces the purely combinational expansion with a 10-cycle sequential engine: one round key per cycle, one shared 4-byte S-box path. It presents all eleven round keys in the bus layout the core already indexes. A `keys_ready` flag tells the controller when `data_vaild` may be raised to the core.

## Interface
- `NR`, default 10: number of expansion rounds; AES-128 only; not to be overridden.
- `clk`  input  1  system clock; all state updates on the rising edge.
- `rst`  input  1  reset; one clock; reset is synchronous and active-low.
- `key_vaild`  input  1  one-cycle request; latches `key` and starts expansion.
- `key`  input  128  cipher key; byte 0 in `[127:120]`.
- `fullkeys`  output  1408  round keys; round key k in `[128k+127 : 128k]`, k = 0..10.
- `keys_ready`  output  1  all 11 round keys valid and stable.
- `busy`  output  1  expansion in progress.

## Operation
- States:
  - `IDLE`: initial state after reset.
  - `EXPAND`: one round key per cycle.
  - `DONE`: holds the completed schedule.
- `IDLE` with `key_vaild`=1:
  - write `key` into slot 0.
  - `rnd` <= 1, `rcon` <= 8'h01.
  - go to `EXPAND`.
- `EXPAND`, each cycle:
  - prev = slot `rnd`-1, split into words w0..w3 (w0 = `[127:96]`).
  - t = SubWord(RotWord(w3)) ^ {`rcon`, 24'h0}.
  - n0 = w0^t; n1 = w1^n0; n2 = w2^n1; n3 = w3^n2.
  - write {n0,n1,n2,n3} to slot `rnd`.
  - `rnd` <= `rnd`+1.
  - `rcon` <= xtime(`rcon`), i.e. shift left 1; XOR 8'h1b if bit 7 was set.
  - sequence: 01,02,04,08,10,20,40,80,1b,36.
- `EXPAND` with `rnd`==10: write slot 10, go to `DONE`.
- `DONE`:
  - `keys_ready`=1; `fullkeys` held.
  - `key_vaild`=1 restarts exactly as from `IDLE` and clears `keys_ready` on the same edge.
- `key_vaild` during `EXPAND` is ignored; `key` is sampled only on the accepting edge.
- `rnd` is 4 bits, range 1..10, never wraps.
- Slots not yet written during `EXPAND` keep their previous contents; they are valid only once `keys_ready`=1.

## Timing
- Reset (`rst`=0 at an edge):
  - state `IDLE`; `fullkeys`=0, `keys_ready`=0, `busy`=0, `rnd`=0, `rcon`=0.
  - Reset mid-expansion aborts immediately; no partial `keys_ready`.
- Acceptance edge E0:
  - `busy`=1 from E0.
  - slot k is written at edge E0+k.
  - at E0+10: `keys_ready`=1, `busy`=0.
  - latency is 10 cycles from acceptance to ready.
- `busy` and `keys_ready` are never both 1.
- `fullkeys` is registered; no combinational path from `key` to `fullkeys`.
- Critical path: one S-box lookup, then a 4-deep XOR chain.

## Structure
- Shared package `aes_pkg`:
  - S-box function/constant table.
  - `xtime`.
  - AES-128 constants (`NR`=10, 128-bit block width).
  - State encoding localparams.
  - Reused by the cipher core.
- One sub-module, `aes_subword`: four parallel S-box lookups, 32-bit in/out, combinational.
- Top level holds the FSM, `rnd`/`rcon` registers and the 1408-bit schedule register.

## Test plan
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c:
  - `keys_ready` rises exactly 10 cycles after acceptance.
  - slot 1 = a0fafe1788542cb123a339392a6c7605.
  - slot 10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
- Key all 0:
  - slot 1 = 62636363626363636263636362636363.
  - slot 0 = 0.
- Key all ff: slot 1 = e8e9e9e917161616e8e9e9e917161616.
- `key_vaild` pulsed again at cycle 4 of expansion with a different key:
  - ignored; result equals the first key's schedule.
  - a new pulse in `DONE` restarts; `keys_ready` is 0 the next cycle, 1 ten cycles later.
- `rst`=0 asserted at cycle 5 of expansion:
  - next cycle `busy`=0, `keys_ready`=0, `fullkeys`=0.
  - a subsequent FIPS key completes correctly.
- Back-to-back integration with `AES`:
  - plaintext 3243f6a8885a308d313198a2e0370734, raised once `keys_ready`=1.
  - ciphertext 3925841d02dc09fbdc118597196a0b32.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES definitions: S-box table, GF(2^8) doubling, AES-128 sizes and
// the key-schedule FSM encoding. Also used by the cipher core.
package aes_pkg;

    localparam int AES_NR     = 10;                       // AES-128 rounds
    localparam int BLOCK_W    = 128;                      // block / round-key width
    localparam int FULLKEYS_W = (AES_NR + 1) * BLOCK_W;   // all eleven round keys

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_EXPAND = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    typedef enum logic [1:0] {
        IDLE   = ST_IDLE,
        EXPAND = ST_EXPAND,
        DONE   = ST_DONE
    } state_t;

    // Forward S-box, entry 0x00 in the top byte, entry 0xff in the bottom byte.
    localparam logic [2047:0] SBOX_FLAT = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_FLAT[(255 - int'(b)) * 8 +: 8];
    endfunction

    // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_key_expand_seq_if.sv
// Key request / round-key bus between the controller and the key expander.
interface aes_key_expand_seq_if;
    import aes_pkg::*;

    logic                  key_vaild;
    logic [BLOCK_W-1:0]    key;
    logic [FULLKEYS_W-1:0] fullkeys;
    logic                  keys_ready;
    logic                  busy;

    modport master (
        output key_vaild, key,
        input  fullkeys, keys_ready, busy
    );

    modport slave (
        input  key_vaild, key,
        output fullkeys, keys_ready, busy
    );

endinterface

// File: rtl/aes_subword.sv
// SubWord: four parallel S-box lookups on a 32-bit word, purely combinational.
module aes_subword
    import aes_pkg::*;
(
    input  logic [31:0] word,
    output logic [31:0] sub
);

    assign sub = {sbox(word[31:24]), sbox(word[23:16]),
                  sbox(word[15:8]),  sbox(word[7:0])};

endmodule

// File: rtl/aes_key_expand_seq.sv
// Iterative AES-128 key schedule: one round key per cycle through a single
// shared SubWord path, all eleven round keys held in one registered bus.
module aes_key_expand_seq
    import aes_pkg::*;
#(
    parameter int NR = AES_NR
) (
    input  logic                 clk,
    input  logic                 rst,
    aes_key_expand_seq_if.slave  bus
);

    state_t                state_q, state_d;
    logic [3:0]            rnd_q;
    logic [7:0]            rcon_q;
    logic [FULLKEYS_W-1:0] sched_q;

    logic                  load_key;
    logic                  step;
    logic [BLOCK_W-1:0]    prev_rk;
    logic [BLOCK_W-1:0]    next_rk;
    logic [31:0]           w0, w1, w2, w3, t, sub;
    logic [31:0]           n0, n1, n2, n3;

    // Select the previous round key (slot rnd-1) as the expansion source.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
        prev_rk = '0;
        for (int k = 0; k < NR; k++) begin
            if (rnd_q == 4'(k + 1)) prev_rk = sched_q[k*BLOCK_W +: BLOCK_W];
        end
    end

    assign {w0, w1, w2, w3} = prev_rk;

    aes_subword u_subword (
        .word ({w3[23:0], w3[31:24]}),   // RotWord
        .sub  (sub)
    );

    assign t  = sub ^ {rcon_q, 24'h0};
    assign n0 = w0 ^ t;
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;
    assign next_rk = {n0, n1, n2, n3};

    // Next-state logic: accept a key from IDLE or DONE, step once per cycle in EXPAND.
    always_comb begin
        state_d  = state_q;
        load_key = 1'b0;
        step     = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (bus.key_vaild) begin
                    load_key = 1'b1;
                    state_d  = EXPAND;
                end
            end
            EXPAND: begin
                step = 1'b1;
                if (rnd_q == 4'(NR)) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Datapath registers: round counter, round constant and the key schedule.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rnd_q   <= '0;
            rcon_q  <= '0;
            sched_q <= '0;
        end else if (load_key) begin
            sched_q[BLOCK_W-1:0] <= bus.key;
            rnd_q                <= 4'd1;
            rcon_q               <= 8'h01;
        end else if (step) begin
            for (int k = 1; k <= NR; k++) begin
                if (rnd_q == 4'(k)) sched_q[k*BLOCK_W +: BLOCK_W] <= next_rk;
            end
            // Counter and constant stop at the last round instead of wrapping.
            if (rnd_q != 4'(NR)) begin
                rnd_q  <= rnd_q + 4'd1;
                rcon_q <= xtime(rcon_q);
            end
        end
    end

    assign bus.fullkeys   = sched_q;
    assign bus.keys_ready = (state_q == DONE);
    assign bus.busy       = (state_q == EXPAND);

endmodule

// File: tb/tb_aes_key_expand_seq.sv
// Scoreboard bench for aes_key_expand_seq: stimulus pushes the expected
// schedule and ready cycle; a monitor checks them when keys_ready rises.
module tb_aes_key_expand_seq;
    import aes_pkg::*;

    typedef struct {
        logic [FULLKEYS_W-1:0] keys;
        logic [10:0]           mask;       // which slots to compare
        int                    ready_cyc;  // expected cycle of keys_ready rise
        string                 tag;
    } exp_t;

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [FULLKEYS_W-1:0] FIPS_SCHED = {
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6,
        128'hac7766f319fadc2128d12941575c006e,
        128'head27321b58dbad2312bf5607f8d292f,
        128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'h6d88a37a110b3efddbf98641ca0093fd,
        128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'hef44a541a8525b7fb671253bdb0bad00,
        128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hf2c295f27a96b9435935807a7359f67f,
        128'ha0fafe1788542cb123a339392a6c7605,
        128'h2b7e151628aed2a6abf7158809cf4f3c
    };

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    logic ready_prev = 1'b0;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    aes_key_expand_seq_if bus();

    aes_key_expand_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [FULLKEYS_W-1:0] keys, input logic [10:0] mask,
                                input string tag);
        exp_t e;
        e.keys = keys;
        e.mask = mask;
        e.ready_cyc = 0;
        e.tag = tag;
        return e;
    endfunction

    // Monitor: checks exclusivity every cycle and the schedule on each ready rise.
    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b1)
            check("busy_ready_excl", 128'(bus.busy & bus.keys_ready), 128'd0);
        if (bus.keys_ready === 1'b1 && ready_prev !== 1'b1) begin
            if (sb.size() == 0) begin
                check("spurious_ready", 128'd1, 128'd0);
            end else begin
                e = sb.pop_front();
                check({e.tag, "_latency"}, 128'(cyc), 128'(e.ready_cyc));
                check({e.tag, "_busy_low"}, 128'(bus.busy), 128'd0);
                for (int k = 0; k <= AES_NR; k++) begin
                    if (e.mask[k])
                        check($sformatf("%s_slot%0d", e.tag, k),
                              bus.fullkeys[k*128 +: 128], e.keys[k*128 +: 128]);
                end
            end
        end
        ready_prev <= bus.keys_ready;
    end

    task automatic start(input logic [127:0] k, input exp_t ex, input bit push);
        exp_t e;
        e = ex;
        @(negedge clk);
        bus.key_vaild = 1'b1;
        bus.key       = k;
        @(posedge clk);
        #1;
        bus.key_vaild = 1'b0;
        bus.key       = ~k;     // key must only matter on the accepting edge
        check({ex.tag, "_busy_after_accept"}, 128'(bus.busy), 128'd1);
        check({ex.tag, "_ready_after_accept"}, 128'(bus.keys_ready), 128'd0);
        if (push) begin
            e.ready_cyc = cyc + 10;
            sb.push_back(e);
        end
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(posedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            check({tag, "_timeout"}, 128'(sb.size()), 128'd0);
            sb.delete();
        end
        repeat (2) @(posedge clk);
    endtask

    initial begin
        rst           = 1'b0;
        bus.key_vaild = 1'b0;
        bus.key       = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_fullkeys", 128'(|bus.fullkeys), 128'd0);
        check("reset_busy", 128'(bus.busy), 128'd0);
        check("reset_ready", 128'(bus.keys_ready), 128'd0);
        @(negedge clk);
        rst = 1'b1;

        // FIPS-197 key, full schedule.
        start(FIPS_KEY, mk(FIPS_SCHED, 11'h7ff, "fips"), 1'b1);
        drain("fips");

        // All-zero key.
        start(128'h0, mk({{9{128'h0}}, 128'h62636363626363636263636362636363, 128'h0},
                         11'h003, "zero"), 1'b1);
        drain("zero");

        // All-ones key.
        start({128{1'b1}}, mk({{9{128'h0}}, 128'he8e9e9e917161616e8e9e9e917161616, {128{1'b1}}},
                              11'h003, "ones"), 1'b1);
        drain("ones");

        // Second request at cycle 4 of expansion is ignored.
        start(FIPS_KEY, mk(FIPS_SCHED, 11'h7ff, "ignore"), 1'b1);
        repeat (3) @(negedge clk);
        bus.key_vaild = 1'b1;
        bus.key       = 128'h0;
        @(posedge clk);
        #1;
        bus.key_vaild = 1'b0;
        check("ignore_still_busy", 128'(bus.busy), 128'd1);
        drain("ignore");

        // Restart from DONE with a different key.
        start(128'h0, mk({{9{128'h0}}, 128'h62636363626363636263636362636363, 128'h0},
                         11'h003, "restart"), 1'b1);
        drain("restart");

        // Reset at cycle 5 of expansion aborts with no ready.
        start(FIPS_KEY, mk(FIPS_SCHED, 11'h7ff, "abort"), 1'b0);
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("abort_busy", 128'(bus.busy), 128'd0);
        check("abort_ready", 128'(bus.keys_ready), 128'd0);
        check("abort_fullkeys", 128'(|bus.fullkeys), 128'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (12) @(posedge clk);
        check("abort_no_ready", 128'(bus.keys_ready), 128'd0);

        // Clean run after the abort.
        start(FIPS_KEY, mk(FIPS_SCHED, 11'h7ff, "post_abort"), 1'b1);
        drain("post_abort");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
